// File: rtl/pcap_replay_scheduler.sv
// PCAP replay scheduler: round-robin arbiter over four AXI-Stream queues,
// forwarding one whole packet at a time with a programmable inter-packet gap.
module pcap_replay_scheduler #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int IPG_WIDTH            = 32
) (
    input  logic                                axi_aclk,
    input  logic                                axi_aresetn,
    input  logic                                sw_rst,
    input  logic [3:0]                          queue_en,
    input  logic [IPG_WIDTH-1:0]                ipg_cycles,
    input  logic [4*C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [4*C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [4*C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [3:0]                          s_axis_tvalid,
    input  logic [3:0]                          s_axis_tlast,
    output logic [3:0]                          s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [4*32-1:0]                     pkt_count,
    output logic                                busy
);

    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           rr_q, rr_d;
    logic [IPG_WIDTH-1:0] gap_q, gap_d;
    logic [31:0]          cnt_q [4];
    logic [31:0]          cnt_d [4];

    logic [3:0] eligible;
    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       sending;
    logic       sel_valid;
    logic       sel_last;
    logic       end_beat;

    assign eligible  = queue_en & s_axis_tvalid;
    assign sending   = (state_q == S_SEND);
    assign sel_valid = s_axis_tvalid[grant_q];
    assign sel_last  = s_axis_tlast[grant_q];
    assign end_beat  = sending && sel_valid && m_axis_tready && sel_last;
    assign busy      = (state_q != S_IDLE);

    // First eligible queue at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (end_beat) begin
                    rr_d  = grant_q + 2'd1;
                    gap_d = ipg_cycles;
                    if (ipg_cycles == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - IPG_WIDTH'(1);
                if (gap_q <= IPG_WIDTH'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            cnt_d[q] = cnt_q[q];
        end
        if (end_beat) begin
            cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            gap_q   <= '0;
            for (int q = 0; q < 4; q++) begin
                cnt_q[q] <= '0;
            end
        end else if (sw_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            gap_q   <= '0;
            for (int q = 0; q < 4; q++) begin
                cnt_q[q] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            for (int q = 0; q < 4; q++) begin
                cnt_q[q] <= cnt_d[q];
            end
        end
    end

    // Payload always follows the granted slice; only the handshake is gated.
    always_comb begin
        m_axis_tdata  = s_axis_tdata[grant_q*DW +: DW];
        m_axis_tstrb  = s_axis_tstrb[grant_q*SW +: SW];
        m_axis_tuser  = s_axis_tuser[grant_q*UW +: UW];
        m_axis_tvalid = sending && sel_valid;
        m_axis_tlast  = sending && sel_last;
        for (int q = 0; q < 4; q++) begin
            s_axis_tready[q] = sending && (grant_q == 2'(q)) && m_axis_tready;
        end
    end

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            pkt_count[q*32 +: 32] = cnt_q[q];
        end
    end

endmodule

// File: tb/tb_pcap_replay_scheduler.sv
// Randomized bench for pcap_replay_scheduler with a transaction-level
// reference model and a handful of hand-derived scenario expectations.
module tb_pcap_replay_scheduler;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int IW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sw_rst = 1'b0;
    logic [3:0]      queue_en = 4'h0;
    logic [IW-1:0]   ipg = '0;
    logic [4*DW-1:0] s_data = '0;
    logic [4*SW-1:0] s_strb = '0;
    logic [4*UW-1:0] s_user = '0;
    logic [3:0]      s_valid = 4'h0;
    logic [3:0]      s_last = 4'h0;
    logic [3:0]      s_ready;
    logic [DW-1:0]   m_data;
    logic [SW-1:0]   m_strb;
    logic [UW-1:0]   m_user;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic            m_last;
    logic [127:0]    pkt_count;
    logic            busy;

    int checks = 0;
    int errors = 0;

    beat_t src [4][$];
    beat_t rx [$];
    beat_t expq [$];
    int    end_q [$];
    longint end_t [$];
    int    gaps [$];
    bit    in_gap = 0;
    int    gap_run = 0;
    longint ncyc = 0;
    bit    rand_rdy = 0;
    bit    seen13 = 0;
    logic [3:0] hs = 4'h0;

    // Reference model: mode 0 idle, 1 sending, 2 gap (ends at cycle mend).
    int          md = 0;
    int          mg = 0;
    int          mr = 0;
    longint      mcyc = 0;
    longint      mend = 0;
    logic [31:0] mc [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

    pcap_replay_scheduler #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .IPG_WIDTH           (IW)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .sw_rst       (sw_rst),
        .queue_en     (queue_en),
        .ipg_cycles   (ipg),
        .s_axis_tdata (s_data),
        .s_axis_tstrb (s_strb),
        .s_axis_tuser (s_user),
        .s_axis_tvalid(s_valid),
        .s_axis_tlast (s_last),
        .s_axis_tready(s_ready),
        .m_axis_tdata (m_data),
        .m_axis_tstrb (m_strb),
        .m_axis_tuser (m_user),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tlast (m_last),
        .pkt_count    (pkt_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input int rr, input logic [3:0] el);
        for (int i = 0; i < 4; i++) begin
            if (el[(rr + i) % 4]) return (rr + i) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || sw_rst) begin
            md <= 0;
            mg <= 0;
            mr <= 0;
            for (int q = 0; q < 4; q++) mc[q] <= 32'd0;
        end else begin
            mcyc <= mcyc + 1;
            case (md)
                0: begin
                    if (rr_pick(mr, queue_en & s_valid) >= 0) begin
                        mg <= rr_pick(mr, queue_en & s_valid);
                        md <= 1;
                    end
                end
                1: begin
                    if (s_valid[mg] && m_ready && s_last[mg]) begin
                        mc[mg] <= mc[mg] + 32'd1;
                        mr     <= (mg + 1) % 4;
                        mend   <= mcyc + longint'(ipg);
                        md     <= (ipg == 0) ? 0 : 2;
                    end
                end
                default: begin
                    if (mcyc == mend) md <= 0;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout got none expected event", nm);
    endtask

    always @(negedge clk) begin : cmp
        logic       ev;
        logic [3:0] er;
        beat_t      b;
        int         qi;
        ncyc++;
        hs = s_valid & s_ready;
        ev = (md == 1) && s_valid[mg];
        er = (md == 1 && m_ready) ? (4'b0001 << mg) : 4'b0000;
        chk("tvalid", m_valid, ev);
        chk("tlast", m_last, (md == 1) ? s_last[mg] : 1'b0);
        chk("s_tready", s_ready, er);
        chk("busy", busy, md != 0);
        chk("pkt_count", pkt_count, {mc[3], mc[2], mc[1], mc[0]});
        if (ev) begin
            chk("tdata", m_data, s_data[mg*DW +: DW]);
            chk("tstrb", m_strb, s_strb[mg*SW +: SW]);
            chk("tuser", m_user, s_user[mg*UW +: UW]);
        end
        if (s_ready[1] || s_ready[3]) seen13 = 1;
        if (!rst_n) in_gap = 0;
        if (m_valid && m_ready) begin
            b.d = m_data;
            b.s = m_strb;
            b.u = m_user;
            b.l = m_last;
            rx.push_back(b);
        end
        if (m_valid && m_ready && m_last) begin
            qi = -1;
            for (int q = 0; q < 4; q++) if (s_ready[q]) qi = q;
            end_q.push_back(qi);
            end_t.push_back(ncyc);
            in_gap  = 1;
            gap_run = 0;
        end else if (in_gap) begin
            if (busy) begin
                gap_run++;
            end else begin
                gaps.push_back(gap_run);
                in_gap = 0;
            end
        end
    end

    task automatic drive();
        for (int q = 0; q < 4; q++) begin
            if (src[q].size() > 0) begin
                s_valid[q]          = 1'b1;
                s_data[q*DW +: DW]  = src[q][0].d;
                s_strb[q*SW +: SW]  = src[q][0].s;
                s_user[q*UW +: UW]  = src[q][0].u;
                s_last[q]           = src[q][0].l;
            end else begin
                s_valid[q] = 1'b0;
                s_last[q]  = 1'b0;
            end
        end
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int q = 0; q < 4; q++) begin
            if (hs[q] && src[q].size() > 0) void'(src[q].pop_front());
        end
        drive();
    endtask

    task automatic push_pkt(input int q, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < DW / 32; k++) b.d[k*32 +: 32] = $urandom();
            for (int k = 0; k < UW / 32; k++) b.u[k*32 +: 32] = $urandom();
            b.s = SW'($urandom());
            b.l = (i == len - 1);
            src[q].push_back(b);
        end
    endtask

    task automatic run_until(input logic [3:0] mask, input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 2000; i++) begin
            done = !busy;
            for (int q = 0; q < 4; q++) begin
                if (mask[q] && src[q].size() > 0) done = 0;
            end
            if (done) break;
            step();
        end
        if (!done) fail_timeout(nm);
        step();
    endtask

    task automatic wait_rx(input int n, input string nm);
        for (int i = 0; i < 300 && rx.size() < n; i++) step();
        if (rx.size() < n) fail_timeout(nm);
    endtask

    task automatic clear_logs();
        end_q.delete();
        end_t.delete();
        gaps.delete();
        rx.delete();
    endtask

    initial begin
        drive();
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_tvalid", m_valid, 1'b0);
        chk("rst_count", pkt_count, 128'd0);
        rst_n = 1'b1;
        step();

        // Four one-packet queues, no gap: strict order 0..3, 4 cycles each.
        clear_logs();
        ipg = 0;
        queue_en = 4'hf;
        for (int q = 0; q < 4; q++) push_pkt(q, 3);
        drive();
        run_until(4'hf, "A_drain");
        chk("A_npkts", end_q.size(), 4);
        for (int i = 0; i < end_q.size() && i < 4; i++) begin
            chk($sformatf("A_order%0d", i), end_q[i], i);
            if (i > 0) chk($sformatf("A_spacing%0d", i), end_t[i] - end_t[i-1], 4);
        end
        chk("A_counts", pkt_count, {32'd1, 32'd1, 32'd1, 32'd1});

        // Only queues 0 and 2 enabled while all four hold traffic.
        clear_logs();
        seen13 = 0;
        queue_en = 4'b0101;
        for (int q = 0; q < 4; q++) begin
            for (int k = 0; k < 4; k++) push_pkt(q, $urandom_range(1, 3));
        end
        drive();
        run_until(4'b0101, "B_drain");
        chk("B_npkts", end_q.size(), 8);
        for (int i = 0; i < end_q.size(); i++) begin
            chk($sformatf("B_grant%0d", i), end_q[i], (i % 2) * 2);
        end
        chk("B_no_ready_1_3", seen13, 1'b0);
        src[1].delete();
        src[3].delete();
        drive();
        step();

        // Gap of 5, reprogrammed to 9 inside the first gap.
        clear_logs();
        queue_en = 4'b0001;
        ipg = 5;
        for (int k = 0; k < 3; k++) push_pkt(0, 2);
        drive();
        for (int i = 0; i < 300 && end_q.size() < 1; i++) step();
        if (end_q.size() < 1) fail_timeout("C_first_end");
        ipg = 9;
        run_until(4'b0001, "C_drain");
        chk("C_ngaps", gaps.size(), 3);
        if (gaps.size() == 3) begin
            chk("C_gap0", gaps[0], 5);
            chk("C_gap1", gaps[1], 9);
            chk("C_gap2", gaps[2], 9);
        end

        // Random backpressure, enable dropped after the first beat.
        clear_logs();
        ipg = 0;
        queue_en = 4'hf;
        rand_rdy = 1;
        push_pkt(1, 6);
        expq = src[1];
        drive();
        wait_rx(1, "D_first_beat");
        queue_en[1] = 1'b0;
        run_until(4'b0010, "D_drain");
        rand_rdy = 0;
        drive();
        chk("D_nbeats", rx.size(), 6);
        for (int i = 0; i < rx.size() && i < 6; i++) begin
            chk($sformatf("D_data%0d", i), rx[i].d, expq[i].d);
            chk($sformatf("D_last%0d", i), rx[i].l, expq[i].l);
        end
        chk("D_counts", pkt_count, {32'd1, 32'd5, 32'd2, 32'd8});
        queue_en = 4'hf;
        step();

        // Synchronous reset on beat 2 of a 4-beat packet.
        clear_logs();
        push_pkt(2, 4);
        drive();
        wait_rx(1, "E_first_beat");
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        src[2].delete();
        drive();
        #1;
        chk("E_busy", busy, 1'b0);
        chk("E_tvalid", m_valid, 1'b0);
        chk("E_tready", s_ready, 4'h0);
        chk("E_count", pkt_count, 128'd0);
        step();

        // Asynchronous reset asserted between edges mid-packet.
        clear_logs();
        push_pkt(0, 1);
        push_pkt(3, 3);
        drive();
        wait_rx(2, "F_mid_packet");
        chk("F_pre_count", pkt_count, {32'd0, 32'd0, 32'd0, 32'd1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_busy", busy, 1'b0);
        chk("F_tvalid", m_valid, 1'b0);
        chk("F_tlast", m_last, 1'b0);
        chk("F_tready", s_ready, 4'h0);
        chk("F_count", pkt_count, 128'd0);
        for (int q = 0; q < 4; q++) src[q].delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
